// File: rtl/asym_ram_sdp_stream.sv
// Write-wider simple-dual-port RAM with lane enables, streaming writes, clear sequencer.
// Optional sticky stream-wrap flag wr_ovf is built when ASYM_RAM_STREAM_OVF_EN is defined.
module asym_ram_sdp_stream #(
    parameter int DATAWIDTHB = 16,
    parameter int RATIO = 4,
    parameter int ADDRWIDTHB = 12,
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 2,
    parameter logic [DATAWIDTHB-1:0] INIT_VALUE = '0,
    parameter string RAM_STYLE = "block",
    localparam int DATAWIDTHA = DATAWIDTHB * RATIO,
    localparam int RLOG = $clog2(RATIO),
    localparam int ADDRWIDTHA = ADDRWIDTHB - RLOG
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_mode,
    input  logic [ADDRWIDTHA-1:0] wr_addr,
    input  logic                  wr_start,
    input  logic [RATIO-1:0]      wr_lane,
    input  logic [DATAWIDTHA-1:0] wr_data,
    output logic [ADDRWIDTHA-1:0] wr_ptr,
    input  logic                  clear,
    output logic                  busy,
    input  logic                  rd_en,
    input  logic [ADDRWIDTHB-1:0] rd_addr,
    output logic [DATAWIDTHB-1:0] rd_data,
    output logic                  rd_valid
`ifdef ASYM_RAM_STREAM_OVF_EN
    ,
    output logic                  wr_ovf
`endif
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    (* ram_style = RAM_STYLE *)
    logic [DATAWIDTHB-1:0] r_mem [0:(2**ADDRWIDTHB)-1];

    state_t                r_state;
    logic                  r_busy;
    logic                  r_clr_pend;
    logic [ADDRWIDTHA-1:0] r_clr_addr;
    logic [ADDRWIDTHA-1:0] r_wr_ptr;

    logic                  w_acc;
    logic                  w_start;
    logic                  w_stream;
    logic [ADDRWIDTHA-1:0] w_base;
    logic [ADDRWIDTHA-1:0] w_in_addr;

    logic                  w_c_vld;
    logic [ADDRWIDTHA-1:0] w_c_addr;
    logic [RATIO-1:0]      w_c_lane;
    logic [DATAWIDTHA-1:0] w_c_data;
    logic                  w_pipe_empty;

    logic                  w_we;
    logic [ADDRWIDTHA-1:0] w_waddr;
    logic [RATIO-1:0]      w_wlane;
    logic [DATAWIDTHA-1:0] w_wdata;

    // Stream address is resolved at the input so wr_ptr moves immediately.
    assign w_acc     = wr_en & ~r_busy;
    assign w_start   = wr_start & ~r_busy;
    assign w_stream  = w_acc & wr_mode;
    assign w_base    = w_start ? wr_addr : r_wr_ptr;
    assign w_in_addr = wr_mode ? w_base : wr_addr;

    generate
        if (WR_LATENCY == 0) begin : g_wr_direct
            assign w_c_vld      = w_acc;
            assign w_c_addr     = w_in_addr;
            assign w_c_lane     = wr_lane;
            assign w_c_data     = wr_data;
            assign w_pipe_empty = 1'b1;
        end else begin : g_wr_pipe
            logic                  r_vld  [WR_LATENCY];
            logic [ADDRWIDTHA-1:0] r_addr [WR_LATENCY];
            logic [RATIO-1:0]      r_lane [WR_LATENCY];
            logic [DATAWIDTHA-1:0] r_data [WR_LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < WR_LATENCY; i++) begin
                        r_vld[i]  <= 1'b0;
                        r_addr[i] <= '0;
                        r_lane[i] <= '0;
                        r_data[i] <= '0;
                    end
                end else begin
                    r_vld[0]  <= w_acc;
                    r_addr[0] <= w_in_addr;
                    r_lane[0] <= wr_lane;
                    r_data[0] <= wr_data;
                    for (int i = 1; i < WR_LATENCY; i++) begin
                        r_vld[i]  <= r_vld[i-1];
                        r_addr[i] <= r_addr[i-1];
                        r_lane[i] <= r_lane[i-1];
                        r_data[i] <= r_data[i-1];
                    end
                end
            end

            // A write accepted this cycle also counts, so a clear never races it.
            always_comb begin
                w_pipe_empty = ~w_acc;
                for (int i = 0; i < WR_LATENCY; i++) begin
                    if (r_vld[i]) w_pipe_empty = 1'b0;
                end
            end

            assign w_c_vld  = r_vld[WR_LATENCY-1];
            assign w_c_addr = r_addr[WR_LATENCY-1];
            assign w_c_lane = r_lane[WR_LATENCY-1];
            assign w_c_data = r_data[WR_LATENCY-1];
        end
    endgenerate

    assign w_we    = (r_state == S_CLEAR) | w_c_vld;
    assign w_waddr = (r_state == S_CLEAR) ? r_clr_addr : w_c_addr;
    assign w_wlane = (r_state == S_CLEAR) ? '1 : w_c_lane;
    assign w_wdata = (r_state == S_CLEAR) ? {RATIO{INIT_VALUE}} : w_c_data;

    always_ff @(posedge clk) begin
        for (int i = 0; i < RATIO; i++) begin
            if (w_we && w_wlane[i]) begin
                r_mem[(ADDRWIDTHB'(w_waddr) << RLOG) | ADDRWIDTHB'(i)]
                    <= w_wdata[i*DATAWIDTHB +: DATAWIDTHB];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_stream) begin
                r_wr_ptr <= w_base + 1'b1;
            end else if (w_start) begin
                r_wr_ptr <= wr_addr;
            end
            unique case (r_state)
                S_IDLE: begin
                    if ((clear | r_clr_pend) & w_pipe_empty) begin
                        r_state    <= S_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_pend <= 1'b0;
                        r_clr_addr <= '0;
                    end else if (clear) begin
                        r_clr_pend <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (&r_clr_addr) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    r_clr_addr <= r_clr_addr + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic                  r_rv [RD_LATENCY];
    logic [DATAWIDTHB-1:0] r_rd [RD_LATENCY];

    // Data stages load only behind a valid, so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_rv[i] <= 1'b0;
                r_rd[i] <= '0;
            end
        end else begin
            r_rv[0] <= rd_en;
            if (rd_en) r_rd[0] <= r_mem[rd_addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rv[i] <= r_rv[i-1];
                if (r_rv[i-1]) r_rd[i] <= r_rd[i-1];
            end
        end
    end

`ifdef ASYM_RAM_STREAM_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_start) begin
            r_ovf <= 1'b0;
        end else if (w_stream && (&w_base)) begin
            r_ovf <= 1'b1;
        end
    end

    assign wr_ovf = r_ovf;
`endif

    assign wr_ptr   = r_wr_ptr;
    assign busy     = r_busy;
    assign rd_data  = r_rd[RD_LATENCY-1];
    assign rd_valid = r_rv[RD_LATENCY-1];

endmodule

// File: tb/tb_asym_ram_sdp_stream.sv
// Bench for asym_ram_sdp_stream: three instances (read latency 3, 1, 4) share stimulus.
// Reads are checked against an issue log with per-instance latency.
module tb_asym_ram_sdp_stream;

    localparam int AB = 12;
    localparam int AA = 10;
    localparam int DB = 16;
    localparam int R  = 4;
    localparam int DA = 64;
    localparam logic [DB-1:0] INITV = 16'h5A5A;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          wr_mode;
    logic          wr_start;
    logic [AA-1:0] wr_addr;
    logic [R-1:0]  wr_lane;
    logic [DA-1:0] wr_data;
    logic          clear;
    logic          rd_en;
    logic [AB-1:0] rd_addr;

    logic [AA-1:0] ptr [3];
    logic          bsy [3];
    logic          rv  [3];
    logic [DB-1:0] rdd [3];
`ifdef ASYM_RAM_STREAM_OVF_EN
    logic          ovf [3];
`endif

    for (genvar k = 0; k < 3; k++) begin : g_dut
        asym_ram_sdp_stream #(
            .DATAWIDTHB(DB),
            .RATIO(R),
            .ADDRWIDTHB(AB),
            .RD_LATENCY(k == 0 ? 3 : (k == 1 ? 1 : 4)),
            .WR_LATENCY(2),
            .INIT_VALUE(INITV),
            .RAM_STYLE("block")
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .wr_en(wr_en),
            .wr_mode(wr_mode),
            .wr_addr(wr_addr),
            .wr_start(wr_start),
            .wr_lane(wr_lane),
            .wr_data(wr_data),
            .wr_ptr(ptr[k]),
            .clear(clear),
            .busy(bsy[k]),
            .rd_en(rd_en),
            .rd_addr(rd_addr),
            .rd_data(rdd[k]),
            .rd_valid(rv[k])
`ifdef ASYM_RAM_STREAM_OVF_EN
            ,
            .wr_ovf(ovf[k])
`endif
        );
    end

    always #5 clk = ~clk;

    int            n_tests;
    int            n_fail;
    int            cyc;
    int            n_iss;
    int            idx [3];
    bit            mon_en;
    logic [DB-1:0] rec_exp [16384];
    int            rec_cyc [16384];
    logic [DB-1:0] refm [4096];
    logic [AA-1:0] m_ptr;

    typedef struct {
        int            phase;
        logic [AB-1:0] addr;
        logic [DB-1:0] exp;
    } vec_t;

    vec_t tv [8];

    function automatic int lat(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 1 : 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    n_tests++;
                    if (idx[k] >= n_iss) begin
                        n_fail++;
                        $display("FAIL rd_spurious dut%0d: rd_valid=1 at cycle %0d, expected no read",
                                 k, cyc);
                    end else begin
                        if (cyc != rec_cyc[idx[k]] + lat(k) || rdd[k] !== rec_exp[idx[k]]) begin
                            n_fail++;
                            $display("FAIL rd dut%0d #%0d: got %h at cycle %0d, expected %h at cycle %0d",
                                     k, idx[k], rdd[k], cyc, rec_exp[idx[k]],
                                     rec_cyc[idx[k]] + lat(k));
                        end
                        idx[k]++;
                    end
                end else if (idx[k] < n_iss && cyc >= rec_cyc[idx[k]] + lat(k)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_missing dut%0d #%0d: rd_valid=0 at cycle %0d, expected 1",
                             k, idx[k], cyc);
                    idx[k]++;
                end
            end
        end
    endtask

    task automatic rd_issue(input logic [AB-1:0] a, input logic [DB-1:0] e);
        rd_en = 1'b1;
        rd_addr = a;
        rec_exp[n_iss] = e;
        rec_cyc[n_iss] = cyc;
        n_iss++;
        tick();
    endtask

    task automatic drain();
        rd_en = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wr(input logic mode, input logic start, input logic [AA-1:0] a,
                      input logic [R-1:0] lane, input logic [DA-1:0] d);
        logic [AA-1:0] base;
        logic [AA-1:0] word;
        wr_en = 1'b1;
        wr_mode = mode;
        wr_start = start;
        wr_addr = a;
        wr_lane = lane;
        wr_data = d;
        base = start ? a : m_ptr;
        word = mode ? base : a;
        for (int i = 0; i < R; i++) begin
            if (lane[i]) refm[int'(word) * R + i] = d[i*DB +: DB];
        end
        if (mode) m_ptr = base + 1'b1;
        else if (start) m_ptr = a;
        tick();
        wr_en = 1'b0;
        wr_start = 1'b0;
        wr_mode = 1'b0;
    endtask

    initial begin
        int cnt;
        n_tests = 0;
        n_fail = 0;
        cyc = 0;
        n_iss = 0;
        mon_en = 1'b0;
        m_ptr = '0;
        for (int k = 0; k < 3; k++) idx[k] = 0;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_mode = 1'b0;
        wr_start = 1'b0;
        wr_addr = '0;
        wr_lane = '0;
        wr_data = '0;
        clear = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;

        tv[0] = '{0, 12'd20, 16'h1111};
        tv[1] = '{0, 12'd21, 16'h2222};
        tv[2] = '{0, 12'd22, 16'h3333};
        tv[3] = '{0, 12'd23, 16'h4444};
        tv[4] = '{1, 12'd20, 16'h1111};
        tv[5] = '{1, 12'd21, 16'hABCD};
        tv[6] = '{1, 12'd22, 16'h3333};
        tv[7] = '{1, 12'd23, 16'h4444};

        repeat (3) tick();
        chk("reset_wr_ptr", ptr[0], 0);
        chk("reset_busy", bsy[0], 0);
        chk("reset_rd_valid", rv[0], 0);
        chk("reset_rd_data", rdd[0], 0);
`ifdef ASYM_RAM_STREAM_OVF_EN
        chk("reset_wr_ovf", ovf[0], 0);
`endif
        reset = 1'b0;
        tick();
        mon_en = 1'b1;

        for (int p = 0; p < 2; p++) begin
            if (p == 0) wr(1'b0, 1'b0, 10'd5, 4'b1111, 64'h4444_3333_2222_1111);
            else wr(1'b0, 1'b0, 10'd5, 4'b0010, 64'hFFFF_FFFF_ABCD_FFFF);
            repeat (3) tick();
            chk("addr_mode_ptr_hold", ptr[0], 0);
            for (int i = 0; i < 8; i++) begin
                if (tv[i].phase == p) rd_issue(tv[i].addr, tv[i].exp);
            end
            drain();
        end

        wr_addr = 10'd1022;
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        m_ptr = 10'd1022;
        wr(1'b1, 1'b0, 10'd0, 4'hF, 64'hA003_A002_A001_A000);
        wr(1'b1, 1'b0, 10'd0, 4'hF, 64'hB003_B002_B001_B000);
        wr(1'b1, 1'b0, 10'd0, 4'hF, 64'hC003_C002_C001_C000);
        chk("stream_wr_ptr", ptr[0], 1);
`ifdef ASYM_RAM_STREAM_OVF_EN
        chk("stream_wr_ovf", ovf[0], 1);
`endif
        repeat (3) tick();
        rd_issue(12'd4088, 16'hA000);
        rd_issue(12'd4091, 16'hA003);
        rd_issue(12'd4092, 16'hB000);
        rd_issue(12'd4095, 16'hB003);
        rd_issue(12'd0, 16'hC000);
        rd_issue(12'd3, 16'hC003);
        drain();

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("busy_rise", bsy[0], 1);
        cnt = 0;
        while (bsy[0] && cnt < 2000) begin
            cnt++;
            wr_en = (cnt == 10 || cnt == 20);
            wr_start = (cnt == 20);
            wr_mode = (cnt == 20);
            wr_addr = (cnt == 20) ? 10'd500 : 10'd3;
            wr_lane = '1;
            wr_data = '1;
            tick();
        end
        wr_en = 1'b0;
        wr_start = 1'b0;
        wr_mode = 1'b0;
        chk("busy_cycles", cnt, 1024);
        chk("busy_drop_ptr", ptr[0], 1);
        for (int a = 0; a < 4096; a++) refm[a] = INITV;
        for (int a = 0; a < 4096; a++) rd_issue(a[AB-1:0], refm[a]);
        drain();

        wr(1'b0, 1'b0, 10'd7, 4'hF, 64'h7777_7777_7777_7777);
        tick();
        rd_issue(12'd28, INITV);
        rd_issue(12'd28, 16'h7777);
        drain();

        wr(1'b1, 1'b1, 10'd10, 4'hF, 64'h0D03_0D02_0D01_0D00);
        chk("start_stream_ptr", ptr[0], 11);
`ifdef ASYM_RAM_STREAM_OVF_EN
        chk("start_clears_ovf", ovf[0], 0);
`endif
        wr(1'b1, 1'b0, 10'd0, 4'b1001, 64'hE003_E002_E001_E000);
        chk("stream_lane_ptr", ptr[0], 12);
        wr(1'b1, 1'b1, 10'd1023, 4'hF, 64'hF003_F002_F001_F000);
        chk("start_wrap_ptr", ptr[0], 0);
`ifdef ASYM_RAM_STREAM_OVF_EN
        chk("start_wins_ovf", ovf[0], 0);
`endif
        wr(1'b1, 1'b0, 10'd0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lane0_ptr_adv", ptr[0], 1);
        repeat (3) tick();
        rd_issue(12'd40, 16'h0D00);
        rd_issue(12'd43, 16'h0D03);
        rd_issue(12'd44, 16'hE000);
        rd_issue(12'd45, INITV);
        rd_issue(12'd46, INITV);
        rd_issue(12'd47, 16'hE003);
        rd_issue(12'd4092, 16'hF000);
        rd_issue(12'd0, INITV);
        drain();

        for (int a = 40; a < 56; a++) rd_issue(a[AB-1:0], refm[a]);
        drain();

        wr(1'b0, 1'b0, 10'd0, 4'hF, 64'h1111_1111_1111_1111);
        wr(1'b0, 1'b0, 10'd50, 4'hF, 64'h2222_2222_2222_2222);
        wr(1'b0, 1'b0, 10'd99, 4'hF, 64'h3333_3333_3333_3333);
        wr(1'b0, 1'b0, 10'd1000, 4'hF, 64'h1003_1002_1001_1000);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_held", bsy[0], 0);
        cnt = 0;
        while (!bsy[0] && cnt < 20) begin
            cnt++;
            tick();
        end
        chk("clear_pending_taken", bsy[0], 1);
        repeat (99) tick();
        mon_en = 1'b0;
        rd_en = 1'b1;
        rd_addr = 12'd4000;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_en = 1'b0;
        chk("abort_busy", bsy[0], 0);
        chk("abort_rd_valid_l3", rv[0], 0);
        chk("abort_rd_valid_l1", rv[1], 0);
        chk("abort_ptr", ptr[0], 0);
        m_ptr = '0;
        for (int k = 0; k < 3; k++) idx[k] = n_iss;
        tick();
        mon_en = 1'b1;
        for (int a = 0; a < 400; a++) refm[a] = INITV;
        for (int a = 0; a < 400; a++) rd_issue(a[AB-1:0], refm[a]);
        rd_issue(12'd4000, 16'h1000);
        rd_issue(12'd4001, 16'h1001);
        rd_issue(12'd4002, 16'h1002);
        rd_issue(12'd4003, 16'h1003);
        drain();

        for (int k = 0; k < 3; k++) chk("rd_all_returned", idx[k], n_iss);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/asym_ram_sdp_stream.md
Name: asym_ram_sdp_stream

Overview:
- Single-clock, simple-dual-port asymmetric RAM. The write port is RATIO times wider than the read port.
- Next generation of the team's write-wider buffer. Adds:
  - per-lane write enables
  - a streaming write mode with auto-incrementing address
  - a hardware clear sequencer
  - parametrised read latency with a valid flag
- Sits between the command/waveform loader, which writes wide words, and the DAC sample path, which reads narrow samples.

Parameters:
- DATAWIDTHB, 16, read data width in bits.
- RATIO, 4, write/read width ratio. Power of two, 1..16.
- ADDRWIDTHB, 12, read address width. Depth = 2**ADDRWIDTHB narrow words.
- RD_LATENCY, 3, cycles from rd_en to rd_valid/rd_data. Legal range 1..4.
- WR_LATENCY, 2, input register stages on the write path before the array. Legal range 0..3.
- INIT_VALUE, 0, narrow-word value written by the clear sequencer.
- RAM_STYLE, "block", synthesis ram_style attribute.

Derived constants:
- DATAWIDTHA = DATAWIDTHB*RATIO.
- ADDRWIDTHA = ADDRWIDTHB - log2(RATIO).

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_mode  in  1  0 = addressed write, 1 = streaming write.
- wr_addr  in  ADDRWIDTHA  wide-word address in addressed mode; start address loaded by wr_start.
- wr_start  in  1  loads the stream pointer from wr_addr.
- wr_lane  in  RATIO  per-lane write enable. Lane i = wr_data[(i+1)*DATAWIDTHB-1 -: DATAWIDTHB] and goes to narrow address {word_addr, i}.
- wr_data  in  DATAWIDTHA  wide write data.
- wr_ptr  out  ADDRWIDTHA  current stream pointer.
- clear  in  1  starts the clear sequence.
- busy  out  1  high while the clear sequence runs.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDRWIDTHB  narrow-word read address.
- rd_data  out  DATAWIDTHB  read data.
- rd_valid  out  1  rd_data valid.

Behaviour:
- Reset values:
  - wr_ptr=0, busy=0, rd_valid=0, rd_data=0.
  - All pipeline registers are cleared.
  - RAM contents are not affected by reset.
- Write path:
  - wr_en, wr_mode, wr_addr, wr_lane and wr_data pass through WR_LATENCY register stages, then commit to the array.
  - Written data is visible to a read issued WR_LATENCY+1 cycles after the write, or later.
- Addressed mode (wr_mode=0): the write targets the word at wr_addr. wr_ptr is unchanged.
- Streaming mode (wr_mode=1): the write targets the word at wr_ptr, then wr_ptr increments by 1. The pointer wraps from 2**ADDRWIDTHA-1 to 0 with no flag.
- wr_start:
  - Sets wr_ptr=wr_addr on the next edge.
  - If wr_start and a streaming wr_en occur in the same cycle: the write goes to wr_addr and wr_ptr becomes wr_addr+1.
- Lanes with wr_lane[i]=0 retain their old contents. wr_lane=0 with wr_en=1 is a no-op, but the pointer still advances in streaming mode.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: on clear=1, provided the write pipeline is empty; busy rises on the next edge.
  - If the pipeline is not empty, the clear request is held and taken once the pipeline drains.
  - CLEAR: the sequencer writes INIT_VALUE to all lanes of one wide word per cycle, for words 0..2**ADDRWIDTHA-1.
  - CLEAR -> IDLE after the last word; busy falls on that edge. busy is high for exactly 2**ADDRWIDTHA cycles.
  - While busy: wr_en and wr_start are ignored and dropped. clear is ignored. Reads proceed normally and may return either old data or INIT_VALUE.
  - Reset during CLEAR aborts the sequence. Words already cleared stay cleared; the remaining words are unchanged.
- Read path:
  - rd_data = RAM[rd_addr] registered through RD_LATENCY stages.
  - rd_valid is rd_en delayed by RD_LATENCY.
  - rd_data holds its last value when rd_valid=0.
  - Back-to-back reads are supported every cycle.
- Collision (read and array commit to the same narrow address in the same cycle): the read returns old data.

Optional Feature:
- Macro: ASYM_RAM_STREAM_OVF_EN.
- When defined:
  - Adds output port wr_ovf (1 bit, reset 0).
  - wr_ovf is sticky; it sets on the cycle a streaming write wraps wr_ptr from max to 0.
  - wr_ovf is cleared by wr_start or reset.
  - With wr_start and a wrapping write in the same cycle, wr_start wins.
- When undefined: the port is absent and no logic is generated.

Test Plan:
- Defaults, addressed write wr_addr=5, wr_lane=4'b1111, wr_data=64'h4444_3333_2222_1111; reads at rd_addr 20..23 -> rd_data 16'h1111, 16'h2222, 16'h3333, 16'h4444, each with rd_valid exactly 3 cycles after rd_en.
- Lane mask: write word 5 with wr_lane=4'b0010, data 64'hFFFF_FFFF_ABCD_FFFF -> address 21 reads 16'hABCD; addresses 20, 22, 23 keep their prior values.
- Streaming: wr_start with wr_addr=1022, then 3 streaming writes -> words 1022, 1023, 0 written; wr_ptr=1 afterwards; wr_ovf=1 when the macro is defined.
- Clear: assert clear, and issue writes while busy -> busy high for exactly 1024 cycles; afterwards every address reads INIT_VALUE; the writes issued while busy are absent.
- Reset mid-clear at cycle 100 of CLEAR -> busy=0 and rd_valid=0 on the next cycle; words 0..99 read INIT_VALUE; word 1000 holds its old data.
- Continuous rd_en for 16 cycles with RD_LATENCY=1 and RD_LATENCY=4 -> rd_valid is 16 contiguous cycles shifted by the latency, with data matching a reference model.
